// File: rtl/tlb_bram_mw.sv
// tlb_bram_mw: multi-way 32-bit tag/TLB BRAM driven by an FSL command stream.
// Commands and data arrive on the FSL slave port. Read, burst and lookup
// results are returned on the FSL master port.
//
// Handshake: a slave word is consumed in every cycle where FSL_S_Read is high,
// and FSL_S_Read is high only when FSL_S_Exists=1. A master word is transferred
// in every cycle where FSL_M_Write is high, and FSL_M_Write is high only when
// FSL_M_Full=0. Data and control on either port are meaningful only in those
// transfer cycles.
module tlb_bram_mw #(
  parameter int NUM_WAYS = 4,
  parameter int ADDR_W   = 11
) (
  input  logic        FSL_Clk,
  input  logic        FSL_Rst,
  output logic        FSL_S_Clk,
  output logic        FSL_S_Read,
  input  logic [0:31] FSL_S_Data,
  input  logic        FSL_S_Control,
  input  logic        FSL_S_Exists,
  output logic        FSL_M_Clk,
  output logic        FSL_M_Write,
  output logic [0:31] FSL_M_Data,
  output logic        FSL_M_Control,
  input  logic        FSL_M_Full,
  output logic        Proto_Err,
  output logic [2:0]  dbg_state_o
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_DATA = 3'd1,
    S_LK_KEY  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [NUM_WAYS-1:0]        mask_q, mask_d;
  logic [5:0]                 len_q, len_d;
  logic [31:0]                resp_q, resp_d;
  logic                       ctrl_q, ctrl_d;
  logic                       perr_q, perr_d;
  logic                       wr_en, rd_en;
  logic [ADDR_W-1:0]          rd_addr;
  logic [31:0]                s_word;
  logic [NUM_WAYS-1:0][31:0]  rd_data;
  logic [NUM_WAYS-1:0]        hits;
  logic [31:0]                rd_sel;

  // Bit 0 of the FSL bus is the MSB, so s_word[31] holds FSL_S_Data[0].
  assign s_word = FSL_S_Data;

  // Each way is a separate RAM with a registered read port. The read is issued
  // once per command or burst step, and rd_q holds that word until the next issue.
  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    logic [31:0] mem_q [DEPTH];
    logic [31:0] rd_q;

    // Write port for masked data words, plus the registered read port.
    always_ff @(posedge FSL_Clk) begin
      if (wr_en && mask_q[w]) mem_q[addr_q] <= s_word;
      if (rd_en)              rd_q <= mem_q[rd_addr];
    end

    assign rd_data[w] = rd_q;
  end

  // Per-way hit vector and the lowest-numbered masked way's word (0 if no way is masked).
  always_comb begin
    hits   = '0;
    rd_sel = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      hits[w] = mask_q[w] && (rd_data[w] == s_word);
      if (mask_q[w]) rd_sel = rd_data[w];
    end
  end

  // Command FSM state register, plus the latched command fields and response.
  always_ff @(posedge FSL_Clk) begin
    if (FSL_Rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      mask_q  <= '0;
      len_q   <= '0;
      resp_q  <= '0;
      ctrl_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      len_q   <= len_d;
      resp_q  <= resp_d;
      ctrl_q  <= ctrl_d;
      perr_q  <= perr_d;
    end
  end

  // Next-state logic, RAM strobes and response loading.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    len_d   = len_q;
    resp_d  = resp_q;
    ctrl_d  = ctrl_q;
    perr_d  = perr_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    rd_addr = addr_q;
    case (state_q)
      S_IDLE: begin
        if (FSL_S_Exists) begin
          if (FSL_S_Control) begin
            addr_d = s_word[ADDR_W-1:0];
            mask_d = s_word[22 +: NUM_WAYS];
            len_d  = (s_word[31:30] == 2'b11) ? s_word[21:16] : 6'd0;
            case (s_word[31:30])
              2'b01: state_d = S_WR_DATA;
              2'b10: begin
                rd_en   = 1'b1;
                rd_addr = s_word[ADDR_W-1:0];
                state_d = S_LK_KEY;
              end
              default: begin
                rd_en   = 1'b1;
                rd_addr = s_word[ADDR_W-1:0];
                state_d = S_RD_WAIT;
              end
            endcase
          end else begin
            // A data word with no command in progress is dropped and flagged.
            perr_d = 1'b1;
          end
        end
      end
      S_WR_DATA: begin
        if (FSL_S_Exists) begin
          wr_en   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_LK_KEY: begin
        if (FSL_S_Exists) begin
          resp_d     = 32'(hits);
          resp_d[31] = |hits;
          ctrl_d     = 1'b1;
          state_d    = S_RESP;
        end
      end
      S_RD_WAIT: begin
        resp_d  = rd_sel;
        ctrl_d  = 1'b0;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (!FSL_M_Full) begin
          if (len_q != 6'd0) begin
            len_d   = len_q - 6'd1;
            addr_d  = addr_q + ADDR_W'(1);
            rd_en   = 1'b1;
            rd_addr = addr_q + ADDR_W'(1);
            state_d = S_RD_WAIT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign FSL_S_Clk     = FSL_Clk;
  assign FSL_M_Clk     = FSL_Clk;
  assign FSL_S_Read    = FSL_S_Exists &&
                         (state_q == S_IDLE || state_q == S_WR_DATA || state_q == S_LK_KEY);
  // Reset suppresses any pending push in the same cycle.
  assign FSL_M_Write   = (state_q == S_RESP) && !FSL_M_Full && !FSL_Rst;
  assign FSL_M_Data    = resp_q;
  assign FSL_M_Control = ctrl_q;
  assign Proto_Err     = perr_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_tlb_bram_mw.sv
// Testbench for tlb_bram_mw with 8 ways and a 16-word depth.
// The bench keeps a word-level model of every way and a queue of expected master words.
module tb_tlb_bram_mw;

  localparam int NW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic        FSL_Clk = 1'b0;
  logic        FSL_Rst;
  logic        FSL_S_Clk, FSL_S_Read, FSL_S_Control, FSL_S_Exists;
  logic [0:31] FSL_S_Data;
  logic        FSL_M_Clk, FSL_M_Write, FSL_M_Control, FSL_M_Full;
  logic [0:31] FSL_M_Data;
  logic        Proto_Err;
  logic [2:0]  dbg_state;

  always #5 FSL_Clk = ~FSL_Clk;

  tlb_bram_mw #(.NUM_WAYS(NW), .ADDR_W(AW)) dut (
    .FSL_Clk(FSL_Clk), .FSL_Rst(FSL_Rst),
    .FSL_S_Clk(FSL_S_Clk), .FSL_S_Read(FSL_S_Read), .FSL_S_Data(FSL_S_Data),
    .FSL_S_Control(FSL_S_Control), .FSL_S_Exists(FSL_S_Exists),
    .FSL_M_Clk(FSL_M_Clk), .FSL_M_Write(FSL_M_Write), .FSL_M_Data(FSL_M_Data),
    .FSL_M_Control(FSL_M_Control), .FSL_M_Full(FSL_M_Full),
    .Proto_Err(Proto_Err), .dbg_state_o(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pop_cyc  = 0;
  int push_cnt = 0;
  int last_push_cyc = 0;
  bit gaps = 0, rand_full = 0, hold_full = 0;

  logic [32:0] in_q[$];   // {control, data} words waiting on the slave port
  logic [32:0] exp_q[$];  // {control, data} words expected on the master port
  logic [31:0] ref_mem [NW][DEPTH];

  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- slave-side driver ----------------
  initial begin
    bit rd;
    FSL_S_Exists  = 1'b0;
    FSL_S_Data    = '0;
    FSL_S_Control = 1'b0;
    FSL_M_Full    = 1'b0;
    forever begin
      @(negedge FSL_Clk);
      FSL_M_Full = hold_full ? 1'b1 : (rand_full ? ($urandom_range(0, 3) == 0) : 1'b0);
      if (in_q.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
        FSL_S_Exists = 1'b1;
        {FSL_S_Control, FSL_S_Data} = in_q[0];
      end else begin
        FSL_S_Exists = 1'b0;
      end
      #1;
      rd = FSL_S_Read;
      if (rd && FSL_S_Control) pop_cyc = cyc;
      @(posedge FSL_Clk);
      cyc++;
      if (rd) void'(in_q.pop_front());
    end
  end

  // ---------------- master-side monitor / scoreboard ----------------
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge FSL_Clk);
      #2;
      if (FSL_M_Write) begin
        push_cnt++;
        last_push_cyc = cyc;
        check("wr_vs_full", 33'(FSL_M_Full), 33'd0);
        check("unexpected_push", 33'(exp_q.size() > 0), 33'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("m_word", {FSL_M_Control, FSL_M_Data}, e);
        end
      end
    end
  end

  // ---------------- reference model + driver tasks ----------------
  function automatic logic [31:0] cmd_word(input logic [1:0] op, input logic [7:0] mask,
                                            input logic [5:0] len, input logic [15:0] addr);
    return {op, mask, len, addr};
  endfunction

  task automatic do_write(input logic [7:0] mask, input logic [15:0] addr, input logic [31:0] d);
    in_q.push_back({1'b1, cmd_word(2'b01, mask, 6'd0, addr)});
    in_q.push_back({1'b0, d});
    for (int w = 0; w < NW; w++)
      if (mask[w]) ref_mem[w][addr % DEPTH] = d;
  endtask

  task automatic do_read(input logic [7:0] mask, input logic [15:0] addr, input int len);
    logic [31:0] v;
    int a;
    in_q.push_back({1'b1, cmd_word((len > 0) ? 2'b11 : 2'b00, mask, 6'(len), addr)});
    for (int i = 0; i <= len; i++) begin
      a = (int'(addr) + i) % DEPTH;
      v = 32'd0;
      for (int w = 0; w < NW; w++)
        if (mask[w]) begin v = ref_mem[w][a]; break; end
      exp_q.push_back({1'b0, v});
    end
  endtask

  task automatic do_lookup(input logic [7:0] mask, input logic [15:0] addr, input logic [31:0] key);
    logic [31:0] r;
    int hit_cnt;
    r = 32'd0;
    hit_cnt = 0;
    in_q.push_back({1'b1, cmd_word(2'b10, mask, 6'd0, addr)});
    in_q.push_back({1'b0, key});
    for (int w = 0; w < NW; w++)
      if (mask[w] && ref_mem[w][addr % DEPTH] == key) begin
        r = r + (32'd1 << w);
        hit_cnt++;
      end
    if (hit_cnt > 0) r = r + 32'h8000_0000;
    exp_q.push_back({1'b1, r});
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && !(in_q.size() == 0 && exp_q.size() == 0); i++)
      @(posedge FSL_Clk);
    check("drain", 33'(in_q.size() + exp_q.size()), 33'd0);
    repeat (3) @(posedge FSL_Clk);
  endtask

  task automatic wait_push(input int n, input int budget);
    for (int i = 0; i < budget && push_cnt < n; i++) @(posedge FSL_Clk);
    check("push_wait", 33'(push_cnt >= n), 33'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    logic [7:0] m;
    logic [15:0] a;
    logic [31:0] d;
    FSL_Rst = 1'b1;
    repeat (3) @(posedge FSL_Clk);
    #2;
    check("rst_s_read",  33'(FSL_S_Read), 33'd0);
    check("rst_m_write", 33'(FSL_M_Write), 33'd0);
    check("rst_m_word",  {FSL_M_Control, FSL_M_Data}, 33'd0);
    check("rst_perr",    33'(Proto_Err), 33'd0);
    @(negedge FSL_Clk);
    FSL_Rst = 1'b0;

    // Give every location a known value that cannot collide with the keys used below.
    for (int i = 0; i < DEPTH; i++) do_write(8'hFF, 16'(i), $urandom | 32'h1000_0000);
    wait_idle(500);

    // Broadcast write, then read each way back and measure the push latency.
    do_write(8'h0F, 16'h005, 32'hCAFE_F00D);
    for (int i = 0; i < 4; i++) begin
      base = push_cnt;
      do_read(8'(1 << i), 16'h005, 0);
      wait_push(base + 1, 50);
      check("rd_latency", 33'(last_push_cyc - pop_cyc), 33'd2);
    end
    wait_idle(100);

    // Lookup hit on way 2, then a miss. Address bits above the 4-bit field are ignored.
    do_write(8'h04, 16'h010, 32'h0000_1234);
    base = push_cnt;
    do_lookup(8'h0F, 16'h010, 32'h0000_1234);
    wait_push(base + 1, 50);
    check("lk_latency", 33'(last_push_cyc - pop_cyc), 33'd2);
    do_lookup(8'h0F, 16'h010, 32'h0000_9999);
    wait_idle(100);

    // Burst that wraps from the top address to address 0.
    do_write(8'h01, 16'd14, 32'hAE);
    do_write(8'h01, 16'd15, 32'hAF);
    do_write(8'h01, 16'd0,  32'hA0);
    do_read(8'h01, 16'd14, 2);
    wait_idle(100);

    // Lookup that hits only in way 7.
    do_write(8'h80, 16'h3, 32'h55);
    do_lookup(8'hFF, 16'h3, 32'h55);
    wait_idle(100);

    // Backpressure: hold Full for 20 cycles during a 4-word burst.
    hold_full = 1;
    base = push_cnt;
    do_read(8'h02, 16'd6, 3);
    repeat (20) @(posedge FSL_Clk);
    check("bp_no_push", 33'(push_cnt - base), 33'd0);
    @(negedge FSL_Clk);
    hold_full = 0;
    wait_idle(100);
    check("bp_count", 33'(push_cnt - base), 33'd4);

    // Randomised traffic with slave gaps and random Full.
    gaps = 1;
    rand_full = 1;
    for (int n = 0; n < 80; n++) begin
      m = 8'($urandom_range(0, 255));
      a = 16'($urandom_range(0, 65535));
      case ($urandom_range(0, 3))
        0: begin
          d = ($urandom_range(0, 1) == 1) ? ref_mem[$urandom_range(0, NW - 1)][a % DEPTH] : $urandom;
          do_write(m, a, d);
        end
        1: do_read(m, a, 0);
        2: begin
          d = ($urandom_range(0, 2) != 0) ? ref_mem[$urandom_range(0, NW - 1)][a % DEPTH] : $urandom;
          do_lookup(m, a, d);
        end
        default: do_read(m, a, $urandom_range(0, 5));
      endcase
    end
    wait_idle(5000);
    gaps = 0;
    rand_full = 0;
    check("perr_clean", 33'(Proto_Err), 33'd0);

    // A data word in IDLE is consumed and sets the sticky error flag.
    base = push_cnt;
    in_q.push_back({1'b0, 32'hDEAD_BEEF});
    wait_idle(50);
    check("perr_set", 33'(Proto_Err), 33'd1);
    check("perr_no_push", 33'(push_cnt - base), 33'd0);

    // Reset in the middle of a burst: remaining words are dropped.
    base = push_cnt;
    do_read(8'h01, 16'd0, 7);
    wait_push(base + 2, 100);
    @(negedge FSL_Clk);
    FSL_Rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge FSL_Clk);
    #2;
    check("rst_mid_perr", 33'(Proto_Err), 33'd0);
    check("rst_mid_write", 33'(FSL_M_Write), 33'd0);
    @(negedge FSL_Clk);
    FSL_Rst = 1'b0;
    base = push_cnt;
    repeat (20) @(posedge FSL_Clk);
    check("rst_no_push", 33'(push_cnt - base), 33'd0);
    do_read(8'h01, 16'd15, 0);
    wait_idle(100);
    check("rst_then_read", 33'(push_cnt - base), 33'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/tlb_bram_mw.md
# tlb_bram_mw

Parametrised multi-way TLB/cache-tag BRAM with an FSL command interface, the successor to the fixed 4-way `tlb_bram`. It sits on a MicroBlaze FSL pair: command and data words arrive on the FSL slave port, and read or lookup results return on the FSL master port. Over the previous block it adds a configurable way count and depth, write broadcast to several ways, burst reads, and a parallel tag-lookup mode that returns a hit mask.

## Interface
- NUM_WAYS, 4: number of 32-bit-wide BRAM ways; legal values 1..8.
- ADDR_W, 11: address width; each way holds 2^ADDR_W words; legal values 1..16.
- FSL_Clk  in  1  single clock for the whole block; one clock, no other domains.
- FSL_Rst  in  1  reset, synchronous, active-high.
- FSL_S_Clk  out  1  tied to FSL_Clk.
- FSL_S_Read  out  1  pops the current slave word.
- FSL_S_Data  in  [0:31]  slave word; bit 0 is the MSB.
- FSL_S_Control  in  1  1 = command word, 0 = data word.
- FSL_S_Exists  in  1  a slave word is available.
- FSL_M_Clk  out  1  tied to FSL_Clk.
- FSL_M_Write  out  1  pushes FSL_M_Data/FSL_M_Control.
- FSL_M_Data  out  [0:31]  response word.
- FSL_M_Control  out  1  0 = read data, 1 = lookup result.
- FSL_M_Full  in  1  master FIFO full; no push while high.
- Proto_Err  out  1  sticky; set when a data word arrives in IDLE; cleared only by FSL_Rst.

## Operation
- Command word fields (FSL_S_Control=1):
  - [0:1] opcode: 00 read, 01 write, 10 lookup, 11 burst read.
  - [2:9] way mask; bit 9 = way 0. Mask bits at or above NUM_WAYS are ignored.
  - [10:15] burst length minus 1 (LEN; burst reads only).
  - [32-ADDR_W:31] address. Other bits are ignored.
- States: IDLE, WR_DATA, LK_KEY, RD_WAIT, RESP.
- IDLE: pop a word when FSL_S_Exists=1.
  - Command word: latch fields and branch.
    - Write goes to WR_DATA.
    - Lookup goes to LK_KEY.
    - Read/burst goes to RD_WAIT; the BRAM read of all ways at the latched address is issued the same cycle.
  - Data word: discard it, set Proto_Err, stay in IDLE.
- WR_DATA: pop the next word regardless of its control bit.
  - Write the word to every masked way at the latched address.
  - A zero mask consumes the word and writes nothing.
  - Go to IDLE.
- LK_KEY: pop the key word. Compare the key with every way's word at the latched address; ways outside the mask never hit. Load the response and go to RESP.
  - Response data: bit 0 = any hit; bits [32-NUM_WAYS:31] = hit mask, way 0 at bit 31; all other bits 0.
  - Response control = 1.
- RD_WAIT: load the response register with the lowest-numbered masked way's word (zero mask gives 0). Response control = 0. Go to RESP.
- RESP: assert FSL_M_Write while FSL_M_Full=0. Once the word is pushed:
  - Burst with words remaining: address = (address+1) mod 2^ADDR_W (wraps), reissue the read, go to RD_WAIT.
  - Otherwise go to IDLE.
- No slave pops occur outside IDLE, WR_DATA and LK_KEY. Backpressure from FSL_M_Full stalls the FSM in RESP only.
- Memory contents are not initialised or cleared by reset.

## Timing
- FSL_S_Read = FSL_S_Exists AND state ∈ {IDLE, WR_DATA, LK_KEY}; it is combinational.
- Read: command popped at cycle 0; FSL_M_Write is high at cycle 2 at the earliest.
- Lookup: key popped at cycle k; FSL_M_Write at k+1 at the earliest. The BRAM read was issued when the command was popped.
- Burst: LEN+1 words; one word every 2 cycles while FSL_M_Full=0.
- FSL_M_Write is high for exactly one cycle per word. FSL_M_Data and FSL_M_Control are stable from the cycle Write rises until the push; Data holds its last value otherwise.
- Write: the data word is written in its pop cycle. A read command popped in the next cycle returns the new value.
- Reset values: FSL_S_Read 0, FSL_M_Write 0, FSL_M_Data 0, FSL_M_Control 0, Proto_Err 0; state IDLE.
- Reset during any state aborts immediately; a pending response or remaining burst words are dropped and nothing is pushed.
- FSL_M_Full rising in RESP holds FSL_M_Write low. Output is resumed the cycle Full falls, with no word lost or duplicated.

## Test plan
- Broadcast write and readback:
  - Stimulus: write mask 0x0F, addr 0x005, data 0xCAFEF00D; then read masks 0x01, 0x02, 0x04, 0x08 at 0x005.
  - Required: four pushes of 0xCAFEF00D, Control=0, each at cycle 2 after its command pop.
- Lookup:
  - Stimulus: write way 2 at 0x010 = 0x1234; lookup mask 0x0F, key 0x1234.
  - Required: response 0x80000004, Control=1.
  - Stimulus: key 0x9999. Required: response 0x00000000.
- Burst wrap with ADDR_W=4:
  - Stimulus: write 0xA0+a to way 0 at addresses 14, 15, 0; burst read LEN=2 at addr 14.
  - Required: pushes 0xAE, 0xAF, 0xA0, in that order.
- Backpressure:
  - Stimulus: FSL_M_Full held high for 20 cycles during a burst of 4.
  - Required: no Write while Full; exactly 4 pushes, in order, after release.
- Protocol error and reset:
  - Stimulus: data word in IDLE. Required: word popped, Proto_Err=1.
  - Stimulus: FSL_Rst mid-burst. Required: Proto_Err=0, Write=0, no further pushes; a following read works normally.
- NUM_WAYS=8:
  - Stimulus: write mask 0x80 at 0x3 = 0x55; lookup key 0x55 with mask 0xFF.
  - Required: response 0x80000080.
